mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester burst arbiter and sequencer in front of the single-port simulation memory. It arbitrates block-sized transfer requests from the instruction-side (requester 0) and data-side (requester 1) cache controllers. It drives the memory word address and write enable one beat per cycle, and returns read data beat by beat to the granted requester. It sits between the cache FSMs and the memory model at the top level.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 64, byte address width
- BLOCK_WORDS, 16, words per burst (power of two, ≥2); BEAT_W = $clog2(BLOCK_WORDS)
- clk  in  1  clock; all state updates on rising edge
- arst  in  1  asynchronous reset, active-high
- i_req  in  2  per-requester transfer request; held until o_done
- i_we  in  2  per-requester direction (1 = block write, 0 = block read)
- i_addr  in  2×ADDR_WIDTH  per-requester byte address of the block
- i_wdata  in  2×DATA_WIDTH  per-requester write word for the current o_beat
- o_gnt  out  2  one-hot grant, high for the whole burst
- o_beat  out  BEAT_W  current beat index
- o_rvalid  out  1  read beat valid (read bursts only)
- o_rdata  out  DATA_WIDTH  read word for o_beat
- o_done  out  2  one-cycle completion pulse to the granted requester
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory byte address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data (combinational from o_mem_addr)

## Operation
- The FSM has two states: IDLE and BURST.
- IDLE, any i_req high:
  - Pick a winner (see Configuration).
  - Latch the winner index, i_we[w], and the aligned base = i_addr[w] with the low BEAT_W+2 bits cleared.
  - Clear the beat counter and go to BURST.
- IDLE, no request: stay in IDLE.
- BURST, every cycle:
  - o_mem_addr = {base[ADDR_WIDTH-1:BEAT_W+2], beat, 2'b00}.
  - o_gnt[w] = 1.
  - Read: o_rvalid = 1, o_rdata = i_mem_rdata.
  - Write: o_mem_we = 1, o_mem_wdata = i_wdata[w]. The requester supplies the data combinationally from o_beat; write data is not latched.
  - The beat counter increments each cycle.
- BURST, beat == BLOCK_WORDS-1: o_done[w] = 1 in the same cycle, then return to IDLE.
- Requester obligations:
  - Hold i_req, i_we and i_addr stable through the burst.
  - Deassert i_req in the cycle after o_done.
  - Dropping i_req mid-burst is ignored; the burst completes.
  - Changing i_addr or i_we mid-burst has no effect, because both are latched at grant.
- IDLE outputs: all zero, including o_mem_we and o_mem_addr. Memory writes can never occur outside BURST.
- Simultaneous requests: exactly one is granted. The loser stays pending and is granted in the IDLE cycle after the current burst.
- Reset, asynchronous and usable mid-burst:
  - State returns to IDLE.
  - All outputs go to 0 immediately, including o_mem_we.
  - The round-robin pointer resets so that requester 0 wins the first tie.
  - The interrupted burst is abandoned without o_done.

## Timing
- Cycle 0: i_req rises while in IDLE.
- Cycles 1..BLOCK_WORDS: beats 0..BLOCK_WORDS-1, one per cycle.
- Cycle BLOCK_WORDS: o_done.
- Cycle BLOCK_WORDS+1: IDLE again.
- Burst occupancy is BLOCK_WORDS+1 cycles, i.e. 17 at the default BLOCK_WORDS.
- Back-to-back bursts have one IDLE bubble between them.
- Read data is combinational from the memory; there are no extra wait states.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - The pointer records the last granted requester.
  - On a tie, the requester that was not last granted wins.
- MEM_ARB_RR_EN undefined: fixed priority, requester 1 (data side) always wins a tie.
  - No pointer register exists.

## Structure
- mem_arb_pkg holds:
  - the state enum typedef (IDLE, BURST)
  - the localparams REQ_I = 0 and REQ_D = 1
  - the function computing BEAT_W
- One combinational sub-module, mem_arb_pick, takes the request vector and the last-grant pointer and returns the winner index. It contains the MEM_ARB_RR_EN conditional.

## Test plan
- Single read: req0 with addr 0x1044 -> o_gnt=01 from cycle 1, o_mem_addr 0x1040, 0x1044, … 0x107C; 16 o_rvalid beats matching the preloaded words; o_done[0] at cycle 16.
- Single write: req1 with we=1, addr 0x2000, wdata = 0xA000+beat -> 16 cycles with o_mem_we=1; a readback burst returns 0xA000..0xA00F.
- Simultaneous requests, MEM_ARB_RR_EN defined: first grant goes to req0, then req1 after one bubble. Repeated simultaneous requests alternate 0,1,0,1.
- Simultaneous requests, MEM_ARB_RR_EN undefined: req1 always granted first. The req0 grant starts in cycle 18.
- Mid-burst events:
  - req dropped at beat 5 -> the burst still ends at beat 15 with o_done.
  - arst at beat 7 of a write -> o_mem_we low at once, o_gnt=00, no o_done; the next request restarts at beat 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory burst arbiter.
// The optional round-robin mode is selected with the MEM_ARB_RR_EN macro (see mem_arb_pick).
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  function automatic int calc_beat_w(input int block_words);
    return $clog2(block_words);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the instruction (0) and data (1) requesters.
// MEM_ARB_RR_EN defined: round-robin on ties; undefined: data side always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       win_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    if (req_i[REQ_I] && req_i[REQ_D]) begin
      // On a tie, whoever was not granted last goes next.
      win_o = ~last_i;
    end else begin
      win_o = req_i[REQ_D];
    end
  end
`else
  logic unused_last;
  assign unused_last = last_i;
  assign win_o       = req_i[REQ_D];
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Burst arbiter/sequencer between the I/D cache controllers and the single-port memory.
// Arbitration policy is fixed-priority by default, round-robin when MEM_ARB_RR_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  ADDR_WIDTH  = 64,
  parameter int  BLOCK_WORDS = 16,
  localparam int BEAT_W      = calc_beat_w(BLOCK_WORDS)
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [1:0]              i_req,
  input  logic [1:0]              i_we,
  input  logic [2*ADDR_WIDTH-1:0] i_addr,
  input  logic [2*DATA_WIDTH-1:0] i_wdata,
  output logic [1:0]              o_gnt,
  output logic [BEAT_W-1:0]       o_beat,
  output logic                    o_rvalid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_done,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output arb_state_e              o_dbg_state
);

  // Handshake: a requester raises i_req with i_we/i_addr stable; o_gnt stays high for
  // BLOCK_WORDS beats, o_done pulses on the last beat, and i_req must drop the cycle after.
  localparam int                HI_W      = ADDR_WIDTH - BEAT_W - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  arb_state_e            state_q;
  logic                  win_q;
  logic [HI_W-1:0]       base_hi_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [1:0]            gnt_q;
  logic [1:0]            done_q;
  logic                  rvalid_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  logic                  win_d;
  logic                  last_gnt;
  logic [ADDR_WIDTH-1:0] req_addr_d;
  logic [HI_W-1:0]       base_hi_d;
  logic [BEAT_W-1:0]     beat_d;
  logic                  unused_addr_lo;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      last_q <= 1'b1;
    end else if (state_q == IDLE && |i_req) begin
      last_q <= win_d;
    end
  end
  assign last_gnt = last_q;
`else
  assign last_gnt = 1'b0;
`endif

  mem_arb_pick u_pick (
    .req_i  (i_req),
    .last_i (last_gnt),
    .win_o  (win_d)
  );

  assign req_addr_d     = win_d ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : i_addr[ADDR_WIDTH-1:0];
  assign base_hi_d      = req_addr_d[ADDR_WIDTH-1:BEAT_W+2];
  assign unused_addr_lo = ^req_addr_d[BEAT_W+1:0];
  assign beat_d         = beat_q + 1'b1;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      win_q      <= 1'b0;
      base_hi_q  <= '0;
      beat_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      rvalid_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|i_req) begin
            state_q    <= BURST;
            win_q      <= win_d;
            base_hi_q  <= base_hi_d;
            beat_q     <= '0;
            gnt_q      <= win_d ? 2'b10 : 2'b01;
            done_q     <= '0;
            mem_we_q   <= i_we[win_d];
            rvalid_q   <= ~i_we[win_d];
            mem_addr_q <= {base_hi_d, {BEAT_W{1'b0}}, 2'b00};
          end
        end
        BURST: begin
          if (beat_q == LAST_BEAT) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rvalid_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
          end else begin
            beat_q     <= beat_d;
            mem_addr_q <= {base_hi_q, beat_d, 2'b00};
            done_q     <= (beat_d == LAST_BEAT) ? gnt_q : 2'b00;
          end
        end
      endcase
    end
  end

  assign o_gnt       = gnt_q;
  assign o_beat      = beat_q;
  assign o_done      = done_q;
  assign o_rvalid    = rvalid_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_dbg_state = state_q;
  // Read and write data pass straight through; only the control path is registered.
  assign o_rdata     = rvalid_q ? i_mem_rdata : '0;
  assign o_mem_wdata = mem_we_q ? (win_q ? i_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                         : i_wdata[DATA_WIDTH-1:0]) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter; a burst-level reference model predicts every beat.
// Build with MEM_ARB_RR_EN defined to exercise the round-robin policy.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 64;
  localparam int BW    = 16;
  localparam int EXP_W = 2 + 4 + 64 + 1 + 1 + 32 + 32 + 2;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          arst;
  logic [1:0]    i_req;
  logic [1:0]    i_we;
  logic [2*AW-1:0] i_addr;
  logic [2*DW-1:0] i_wdata;
  logic [1:0]    o_gnt;
  logic [3:0]    o_beat;
  logic          o_rvalid;
  logic [DW-1:0] o_rdata;
  logic [1:0]    o_done;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  arb_state_e    dbg_state;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk         (clk),
    .arst        (arst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_gnt       (o_gnt),
    .o_beat      (o_beat),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_done      (o_done),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_dbg_state (dbg_state)
  );

  // Simulation memory (16 KB window) and requesters that source write data from o_beat.
  logic [31:0] mem [4096];
  logic [31:0] pat [2];
  assign i_mem_rdata = mem[o_mem_addr[13:2]];
  always @(posedge clk) if (o_mem_we) mem[o_mem_addr[13:2]] <= o_mem_wdata;
  always_comb i_wdata = {pat[1] + 32'(o_beat), pat[0] + 32'(o_beat)};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               start_q[$];
  logic [31:0]      ref_mem [4096];
  int               model_last;
  int               n_checks = 0;
  int               n_fail = 0;

  function automatic logic [31:0] word_init(input int i);
    return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0193);
  endfunction

  function automatic logic [EXP_W-1:0] pack(input logic [1:0] g, input logic [3:0] b,
                                            input logic [63:0] a, input logic we, input logic rv,
                                            input logic [31:0] rd, input logic [31:0] wd,
                                            input logic [1:0] dn);
    return {g, b, a, we, rv, rd, wd, dn};
  endfunction

  task automatic check(input string name, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: one burst = BW word-aligned beats walking the 64-byte block.
  task automatic model_burst(input int k, input logic we, input logic [63:0] a,
                             input logic [31:0] p, input int n_beats, input int n_wr);
    logic [63:0] base, addr;
    logic [1:0]  g, dn;
    logic [11:0] idx;
    logic [31:0] wd;
    base = a & ~64'h3F;
    g    = (k == 1) ? 2'b10 : 2'b01;
    for (int b = 0; b < n_beats; b++) begin
      addr = base + 64'(b * 4);
      idx  = addr[13:2];
      dn   = (b == BW - 1) ? g : 2'b00;
      if (we) begin
        wd = p + 32'(b);
        exp_q.push_back(pack(g, 4'(b), addr, 1'b1, 1'b0, 32'h0, wd, dn));
        if (b < n_wr) ref_mem[idx] = wd;
      end else begin
        exp_q.push_back(pack(g, 4'(b), addr, 1'b0, 1'b1, ref_mem[idx], 32'h0, dn));
      end
    end
    model_last = k;
  endtask

  // Monitor: every beat is popped and compared; idle cycles must drive all zeros.
  always @(negedge clk) begin
    if (!arst) begin
      if (o_gnt != 2'b00) begin
        if (o_beat == 4'd0) start_q.push_back(cyc);
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else check("beat", pack(o_gnt, o_beat, o_mem_addr, o_mem_we, o_rvalid, o_rdata,
                                o_mem_wdata, o_done), exp_q.pop_front());
      end else begin
        check("idle_outputs", {o_done, o_beat, o_rvalid, o_rdata, o_mem_we, o_mem_addr,
                               o_mem_wdata}, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] req, input logic [1:0] we, input logic [63:0] a0,
                       input logic [63:0] a1, input logic [31:0] p0, input logic [31:0] p1,
                       input int drop_beat);
    int         first, c0, budget;
    logic [1:0] pending, d, dropped;
    if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
      first = (model_last == 1) ? 0 : 1;
`else
      first = 1;
`endif
    end else begin
      first = req[1] ? 1 : 0;
    end
    model_burst(first, we[first], first ? a1 : a0, first ? p1 : p0, BW, BW);
    if (req == 2'b11)
      model_burst(1 - first, we[1 - first], first ? a0 : a1, first ? p0 : p1, BW, BW);
    start_q.delete();
    @(posedge clk); #1;
    pat[0] = p0;
    pat[1] = p1;
    i_we   = we;
    i_addr = {a1, a0};
    i_req  = req;
    c0     = cyc;
    pending = req;
    dropped = 2'b00;
    budget  = 0;
    while (pending != 2'b00 && budget < 100) begin
      @(negedge clk);
      d = o_done;
      if (drop_beat >= 0 && o_gnt != 2'b00 && int'(o_beat) == drop_beat) dropped |= o_gnt;
      @(posedge clk); #1;
      pending &= ~d;
      i_req = pending & ~dropped;
      if (dropped != 2'b00) begin
        i_addr = {$urandom, $urandom, $urandom, $urandom};
        i_we   = 2'($urandom_range(0, 3));
      end
      budget++;
    end
    if (pending != 2'b00) fail_now("done_timeout");
    check("queue_drained", EXP_W'(exp_q.size()), '0);
    check("start_first", EXP_W'(start_q.size() > 0 ? start_q[0] : -1), EXP_W'(c0 + 1));
    if (req == 2'b11)
      check("start_second", EXP_W'(start_q.size() > 1 ? start_q[1] : -1), EXP_W'(c0 + BW + 2));
  endtask

  // Write burst from requester 1 hit by reset while beat 7 is on the bus.
  task automatic reset_mid_write(input logic [63:0] a, input logic [31:0] p);
    int budget;
    model_burst(1, 1'b1, a, p, 8, 7);
    @(posedge clk); #1;
    pat[1] = p;
    i_we   = 2'b10;
    i_addr = {a, 64'h0};
    i_req  = 2'b10;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(o_gnt != 2'b00 && o_beat == 4'd7) && budget < 40);
    if (budget >= 40) fail_now("beat7_timeout");
    #1 arst = 1'b1;
    #1;
    check("rst_mem_we", EXP_W'(o_mem_we), '0);
    check("rst_gnt", EXP_W'(o_gnt), '0);
    check("rst_done", EXP_W'(o_done), '0);
    check("rst_addr", EXP_W'(o_mem_addr), '0);
    i_req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    #2 arst = 1'b0;
    model_last = 1;
    check("rst_queue_drained", EXP_W'(exp_q.size()), '0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  r, w;
    logic [63:0] a0, a1;
    int          drop;
    arst   = 1'b1;
    i_req  = 2'b00;
    i_we   = 2'b00;
    i_addr = '0;
    pat[0] = 32'h0;
    pat[1] = 32'h0;
    model_last = 1;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = word_init(i);
      ref_mem[i] = word_init(i);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_gnt", EXP_W'(o_gnt), '0);
    check("reset_mem_we", EXP_W'(o_mem_we), '0);
    check("reset_mem_addr", EXP_W'(o_mem_addr), '0);
    check("reset_done", EXP_W'(o_done), '0);
    @(negedge clk);
    arst = 1'b0;

    issue(2'b01, 2'b00, 64'h1044, 64'h0, 32'h0, 32'h0, -1);
    issue(2'b10, 2'b10, 64'h0, 64'h2000, 32'h0, 32'hA000, -1);
    issue(2'b10, 2'b00, 64'h0, 64'h2000, 32'h0, 32'h0, -1);
    issue(2'b11, 2'b00, 64'h0300, 64'h0700, 32'h0, 32'h0, -1);
    issue(2'b11, 2'b00, 64'h0340, 64'h0740, 32'h0, 32'h0, -1);
    issue(2'b11, 2'b11, 64'h0800, 64'h0800, 32'h1100_0000, 32'h2200_0000, -1);
    issue(2'b01, 2'b00, 64'h1044, 64'h0, 32'h0, 32'h0, 5);
    reset_mid_write(64'h3000, 32'hBEE0_0000);
    issue(2'b10, 2'b00, 64'h0, 64'h3000, 32'h0, 32'h0, -1);
    issue(2'b11, 2'b00, 64'h3000, 64'h1000, 32'h0, 32'h0, -1);

    for (int n = 0; n < 30; n++) begin
      r    = 2'($urandom_range(1, 3));
      w    = 2'($urandom_range(0, 3));
      a0   = 64'($urandom_range(0, 16'h3FFF));
      a1   = 64'($urandom_range(0, 16'h3FFF));
      drop = (r != 2'b11 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      issue(r, w, a0, a1, $urandom, $urandom, drop);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
